// File: rtl/scan_sequencer.sv
// Line-scan sequencer: steps a 4-bit demux select through 16 lines, with a
// blanking gap before each line and an optional per-line enable mask.
module scan_sequencer #(
  parameter int unsigned DWELL = 1000,
  parameter int unsigned BLANK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] line_mask,
  output logic [3:0]  sel,
  output logic        en,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Last-cycle compare values; BLANK_LAST is never used when BLANK is 0.
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_sel;
  logic        r_en;
  logic        r_frame_done;
  logic        r_busy;
  logic [3:0]  w_sel_next;

  assign w_sel_next = r_sel + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel        <= '0;
      r_en         <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (!run) begin
        // Stop wins over every other event, including a pending frame_done.
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_sel   <= '0;
        r_en    <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cnt  <= '0;
            r_sel  <= '0;
            r_busy <= 1'b1;
            if (BLANK > 0) begin
              r_state <= S_BLANK;
              r_en    <= 1'b0;
            end else begin
              r_state <= S_ACTIVE;
              r_en    <= line_mask[0];
            end
          end
          S_BLANK: begin
            r_busy <= 1'b1;
            r_en   <= 1'b0;
            if (r_cnt == BLANK_LAST) begin
              r_state <= S_ACTIVE;
              r_cnt   <= '0;
              r_en    <= line_mask[r_sel];
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          S_ACTIVE: begin
            r_busy <= 1'b1;
            if (r_cnt == DWELL_LAST) begin
              r_cnt <= '0;
              r_sel <= w_sel_next;
              if (r_sel == 4'hF) r_frame_done <= 1'b1;
              // With no blanking, select and enable move on the same edge.
              if (BLANK > 0) begin
                r_state <= S_BLANK;
                r_en    <= 1'b0;
              end else begin
                r_state <= S_ACTIVE;
                r_en    <= line_mask[w_sel_next];
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
              r_en  <= line_mask[r_sel];
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel        = r_sel;
  assign en         = r_en;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: DWELL=4/BLANK=2 instance plus a
// DWELL=1/BLANK=0 instance, sampled 1 ns after each rising edge.
module tb_scan_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] line_mask;
  logic [3:0]  sel;
  logic        en;
  logic        frame_done;
  logic        busy;

  logic        run0;
  logic [15:0] mask0;
  logic [3:0]  sel0;
  logic        en0;
  logic        fd0;
  logic        busy0;

  int n_tests = 0;
  int n_fail  = 0;

  scan_sequencer #(.DWELL(4), .BLANK(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .line_mask  (line_mask),
    .sel        (sel),
    .en         (en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  scan_sequencer #(.DWELL(1), .BLANK(0)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run0),
    .line_mask  (mask0),
    .sel        (sel0),
    .en         (en0),
    .frame_done (fd0),
    .busy       (busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge k after start: 6-cycle line = 2 blank + 4 active; frame every 96 edges.
  task automatic expect_scan(input int k, input logic [15:0] m);
    int pos;
    int line;
    logic [15:0] mm;
    tick();
    pos  = (k - 1) % 6;
    line = ((k - 1) / 6) % 16;
    mm   = m;
    check($sformatf("sel k=%0d", k), 32'(sel), 32'(line));
    check($sformatf("en k=%0d", k), 32'(en), 32'((pos >= 2) && mm[line]));
    check($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
    check($sformatf("fd k=%0d", k), 32'(frame_done), 32'((k > 1) && ((k - 1) % 96 == 0)));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, " sel"}, 32'(sel), 32'd0);
    check({tag, " en"}, 32'(en), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " fd"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    run       = 1'b0;
    line_mask = 16'h0000;
    run0      = 1'b0;
    mask0     = 16'h0000;
    #2 rst_n  = 1'b0;
    #1;
    expect_idle("reset");
    check("reset sel0", 32'(sel0), 32'd0);
    check("reset busy0", 32'(busy0), 32'd0);
    tick();
    tick();

    // Release reset with run high: first frame, all lines lit.
    run       = 1'b1;
    line_mask = 16'hFFFF;
    rst_n     = 1'b1;
    for (int k = 1; k <= 97; k++) expect_scan(k, 16'hFFFF);

    // Odd lines only; change lands during blanking of line 0.
    line_mask = 16'hAAAA;
    for (int k = 98; k <= 226; k++) expect_scan(k, 16'hAAAA);

    // Stop during line 5 ACTIVE.
    run = 1'b0;
    tick();
    expect_idle("stop");
    tick();
    expect_idle("hold");

    // Restart from line 0 with full blanking, then stop on the wrap edge.
    line_mask = 16'hFFFF;
    run       = 1'b1;
    for (int k = 1; k <= 96; k++) expect_scan(k, 16'hFFFF);
    run = 1'b0;
    tick();
    expect_idle("stop on wrap");

    // Async reset in line 1 ACTIVE.
    run = 1'b1;
    for (int k = 1; k <= 9; k++) expect_scan(k, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    expect_idle("async rst");
    tick();
    expect_idle("rst held");

    // Release with run high and an empty mask: timing continues, en stays low.
    line_mask = 16'h0000;
    rst_n     = 1'b1;
    for (int k = 1; k <= 97; k++) expect_scan(k, 16'h0000);
    run = 1'b0;

    // No blanking, one-cycle dwell.
    mask0 = 16'h5A3C;
    run0  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      int s;
      logic [15:0] m0;
      tick();
      s  = (k - 1) % 16;
      m0 = 16'h5A3C;
      check($sformatf("b0 sel k=%0d", k), 32'(sel0), 32'(s));
      check($sformatf("b0 en k=%0d", k), 32'(en0), 32'(m0[s]));
      check($sformatf("b0 busy k=%0d", k), 32'(busy0), 32'd1);
      check($sformatf("b0 fd k=%0d", k), 32'(fd0), 32'((k == 17) || (k == 33)));
    end
    run0 = 1'b0;
    tick();
    check("b0 stop busy", 32'(busy0), 32'd0);
    check("b0 stop sel", 32'(sel0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
